// File: rtl/spif_pkt_pkg.sv
// Shared SpiNNaker multicast packet layout, source tags and the odd-parity helper
// used by every sender that merges traffic onto the transceiver link.
package spif_pkt_pkg;

  localparam int PKT_BITS        = 72;
  localparam int HDR_LSB         = 0;
  localparam int KEY_LSB         = 8;
  localparam int PLD_LSB         = 40;
  localparam int PLD_PRESENT_BIT = 1;
  localparam int PARITY_BIT      = 0;

  typedef enum logic {
    SRC_EVT = 1'b0,
    SRC_DCP = 1'b1
  } src_t;

  // Payload bits of short packets are carried along but never covered by parity.
  function automatic logic odd_parity(input logic [PKT_BITS-1:0] pkt);
    logic [PKT_BITS-1:0] covered;
    covered = pkt;
    covered[PARITY_BIT] = 1'b0;
    if (!pkt[PLD_PRESENT_BIT]) covered[PKT_BITS-1:PLD_LSB] = '0;
    return ~(^covered);
  endfunction

endpackage

// File: rtl/pkt_out_fifo.sv
// Two-entry valid/ready output buffer carrying a packet plus its source tag;
// the head entry is registered and drives the link directly.
module pkt_out_fifo
  import spif_pkt_pkg::*;
#(
  parameter int DATA_BITS = PKT_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] push_data,
  input  src_t                 push_tag,
  input  logic                 push_vld,
  output logic                 push_rdy,
  output logic [DATA_BITS-1:0] pop_data,
  output src_t                 pop_tag,
  output logic                 pop_vld,
  input  logic                 pop_rdy
);

  logic [DATA_BITS-1:0] tail_data;
  src_t                 tail_tag;
  logic [1:0]           count;
  logic                 push;
  logic                 pop;

  assign pop_vld  = (count != 2'd0);
  assign pop      = pop_vld && pop_rdy;
  // A full buffer still takes a new entry when the head leaves in the same cycle.
  assign push_rdy = (count != 2'd2) || pop_rdy;
  assign push     = push_vld && push_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= 2'd0;
      pop_data  <= '0;
      pop_tag   <= SRC_EVT;
      tail_data <= '0;
      tail_tag  <= SRC_EVT;
    end else begin
      if (push && ((count == 2'd0) || (count == 2'd1 && pop))) begin
        pop_data <= push_data;
        pop_tag  <= push_tag;
      end else if (pop && count == 2'd2) begin
        pop_data <= tail_data;
        pop_tag  <= tail_tag;
      end

      if (push && ((count == 2'd1 && !pop) || (count == 2'd2))) begin
        tail_data <= push_data;
        tail_tag  <= push_tag;
      end

      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pkt_transmitter.sv
// Merges diagnostic counter replies and peripheral events onto the outgoing
// multicast link with round-robin arbitration and event parity regeneration.
module pkt_transmitter
  import spif_pkt_pkg::*;
#(
  parameter int PACKET_BITS = PKT_BITS,
  parameter bit FIX_PARITY  = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PACKET_BITS-1:0] dcp_data_in,
  input  logic                   dcp_vld_in,
  output logic                   dcp_rdy_out,
  input  logic [PACKET_BITS-1:0] evt_data_in,
  input  logic                   evt_vld_in,
  output logic                   evt_rdy_out,
  output logic [PACKET_BITS-1:0] pkt_data_out,
  output logic                   pkt_vld_out,
  input  logic                   pkt_rdy_in,
  output logic [1:0]             ptx_cnt_out
);

  src_t                   last_grant;
  src_t                   head_tag;
  src_t                   push_tag;
  logic                   space;
  logic                   dcp_acc;
  logic                   evt_acc;
  logic                   pop;
  logic [PACKET_BITS-1:0] evt_fixed;
  logic [PACKET_BITS-1:0] push_data;

  generate
    if (FIX_PARITY) begin : g_fix
      assign evt_fixed = {evt_data_in[PACKET_BITS-1:PLD_LSB],
                          evt_data_in[PLD_LSB-1:KEY_LSB],
                          evt_data_in[KEY_LSB-1:HDR_LSB+1],
                          odd_parity(evt_data_in)};
    end else begin : g_pass
      assign evt_fixed = evt_data_in;
    end
  endgenerate

  // Each ready is what the grant would be if its own source were valid, so a
  // ready never looks at its own valid; contested cycles favour the source
  // that lost last time.
  assign dcp_rdy_out = !reset && space && (!evt_vld_in || last_grant == SRC_EVT);
  assign evt_rdy_out = !reset && space && (!dcp_vld_in || last_grant == SRC_DCP);

  assign dcp_acc   = dcp_vld_in && dcp_rdy_out;
  assign evt_acc   = evt_vld_in && evt_rdy_out;
  assign push_data = dcp_acc ? dcp_data_in : evt_fixed;
  assign push_tag  = dcp_acc ? SRC_DCP : SRC_EVT;
  assign pop       = pkt_vld_out && pkt_rdy_in;

  pkt_out_fifo #(
    .DATA_BITS (PACKET_BITS)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_data (push_data),
    .push_tag  (push_tag),
    .push_vld  (dcp_acc || evt_acc),
    .push_rdy  (space),
    .pop_data  (pkt_data_out),
    .pop_tag   (head_tag),
    .pop_vld   (pkt_vld_out),
    .pop_rdy   (pkt_rdy_in)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant  <= SRC_EVT;
      ptx_cnt_out <= 2'b00;
    end else begin
      if (dcp_acc)      last_grant <= SRC_DCP;
      else if (evt_acc) last_grant <= SRC_EVT;
      ptx_cnt_out <= pop ? ((head_tag == SRC_DCP) ? 2'b10 : 2'b01) : 2'b00;
    end
  end

endmodule

// File: tb/tb_pkt_transmitter.sv
// Randomised and directed checks of pkt_transmitter against a queue-based model;
// a second instance with parity fixing disabled is checked in lockstep.
module tb_pkt_transmitter;

  localparam int W = 72;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] dcp_data_in, evt_data_in;
  logic         dcp_vld_in, evt_vld_in, pkt_rdy_in;
  logic         dcp_rdy_out, evt_rdy_out, pkt_vld_out;
  logic [W-1:0] pkt_data_out;
  logic [1:0]   ptx_cnt_out;
  logic         raw_dcp_rdy, raw_evt_rdy, raw_pkt_vld;
  logic [W-1:0] raw_pkt_data;
  logic [1:0]   raw_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pkt_transmitter #(.PACKET_BITS(W), .FIX_PARITY(1'b1)) dut (
    .clk(clk), .reset(reset),
    .dcp_data_in(dcp_data_in), .dcp_vld_in(dcp_vld_in), .dcp_rdy_out(dcp_rdy_out),
    .evt_data_in(evt_data_in), .evt_vld_in(evt_vld_in), .evt_rdy_out(evt_rdy_out),
    .pkt_data_out(pkt_data_out), .pkt_vld_out(pkt_vld_out), .pkt_rdy_in(pkt_rdy_in),
    .ptx_cnt_out(ptx_cnt_out)
  );

  pkt_transmitter #(.PACKET_BITS(W), .FIX_PARITY(1'b0)) dut_raw (
    .clk(clk), .reset(reset),
    .dcp_data_in(dcp_data_in), .dcp_vld_in(dcp_vld_in), .dcp_rdy_out(raw_dcp_rdy),
    .evt_data_in(evt_data_in), .evt_vld_in(evt_vld_in), .evt_rdy_out(raw_evt_rdy),
    .pkt_data_out(raw_pkt_data), .pkt_vld_out(raw_pkt_vld), .pkt_rdy_in(pkt_rdy_in),
    .ptx_cnt_out(raw_cnt)
  );

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Parity rule from first principles: count covered ones and make the total odd.
  function automatic logic [W-1:0] ref_fix(input logic [W-1:0] p);
    int ones;
    int top;
    logic [W-1:0] r;
    ones = 0;
    top  = p[1] ? 72 : 40;
    for (int i = 1; i < top; i++) ones += int'(p[i]);
    r    = p;
    r[0] = (ones % 2 == 0);
    return r;
  endfunction

  // Grant the DCP source? Contested cycles go to whoever did not win last.
  function automatic bit picks_dcp(input bit dv, input bit ev, input bit last_dcp);
    if (dv && ev) return !last_dcp;
    return dv;
  endfunction

  function automatic logic [W-1:0] randPkt();
    return {$urandom(), $urandom(), 8'($urandom())};
  endfunction

  // Upstream sources: each holds its front packet until the DUT takes it.
  logic [W-1:0] dcp_src_q[$];
  logic [W-1:0] evt_src_q[$];
  bit dcp_taken = 0;
  bit evt_taken = 0;

  task automatic applyStimulus(input bit is_dcp, input logic [W-1:0] p);
    if (is_dcp) dcp_src_q.push_back(p);
    else        evt_src_q.push_back(p);
  endtask

  always @(posedge clk) begin
    #1;
    if (dcp_taken && dcp_src_q.size() > 0) void'(dcp_src_q.pop_front());
    if (evt_taken && evt_src_q.size() > 0) void'(evt_src_q.pop_front());
    dcp_vld_in  = (dcp_src_q.size() > 0);
    dcp_data_in = (dcp_src_q.size() > 0) ? dcp_src_q[0] : '0;
    evt_vld_in  = (evt_src_q.size() > 0);
    evt_data_in = (evt_src_q.size() > 0) ? evt_src_q[0] : '0;
  end

  typedef struct {
    logic [W-1:0] fixed;
    logic [W-1:0] raw;
    bit           is_dcp;
  } ent_t;

  ent_t       mq[$];
  bit         m_last_dcp = 0;
  logic [1:0] m_cnt      = 2'b00;
  bit         model_on   = 0;

  always @(negedge clk) begin : compare
    bit exp_vld, space, exp_drdy, exp_erdy, pop;
    dcp_taken = dcp_vld_in && dcp_rdy_out;
    evt_taken = evt_vld_in && evt_rdy_out;
    if (model_on) begin
      exp_vld  = (mq.size() > 0);
      space    = !reset && ((mq.size() < 2) || pkt_rdy_in);
      exp_drdy = space && picks_dcp(1'b1, evt_vld_in, m_last_dcp);
      exp_erdy = space && !picks_dcp(dcp_vld_in, 1'b1, m_last_dcp);
      checkOutput("vld", W'(pkt_vld_out), W'(exp_vld));
      checkOutput("raw_vld", W'(raw_pkt_vld), W'(exp_vld));
      checkOutput("cnt", W'(ptx_cnt_out), W'(m_cnt));
      checkOutput("raw_cnt", W'(raw_cnt), W'(m_cnt));
      checkOutput("dcp_rdy", W'(dcp_rdy_out), W'(exp_drdy));
      checkOutput("evt_rdy", W'(evt_rdy_out), W'(exp_erdy));
      checkOutput("raw_dcp_rdy", W'(raw_dcp_rdy), W'(exp_drdy));
      checkOutput("raw_evt_rdy", W'(raw_evt_rdy), W'(exp_erdy));
      if (exp_vld) begin
        checkOutput("data", pkt_data_out, mq[0].fixed);
        checkOutput("raw_data", raw_pkt_data, mq[0].raw);
      end
      if (reset) begin
        mq.delete();
        m_last_dcp = 0;
        m_cnt      = 2'b00;
      end else begin
        pop   = exp_vld && pkt_rdy_in;
        m_cnt = pop ? (mq[0].is_dcp ? 2'b10 : 2'b01) : 2'b00;
        if (pop) void'(mq.pop_front());
        if (dcp_vld_in && exp_drdy) begin
          mq.push_back('{fixed: dcp_data_in, raw: dcp_data_in, is_dcp: 1'b1});
          m_last_dcp = 1;
        end else if (evt_vld_in && exp_erdy) begin
          mq.push_back('{fixed: ref_fix(evt_data_in), raw: evt_data_in, is_dcp: 1'b0});
          m_last_dcp = 0;
        end
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic waitAccept(input bit is_dcp, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = is_dcp ? (dcp_vld_in && dcp_rdy_out) : (evt_vld_in && evt_rdy_out);
    end
    checkOutput(is_dcp ? "dcp_accept_timeout" : "evt_accept_timeout", W'(seen), W'(1));
  endtask

  task automatic waitPulse(input int budget, output logic [1:0] val);
    val = 2'b00;
    for (int i = 0; i < budget && val == 2'b00; i++) begin
      @(negedge clk);
      val = ptx_cnt_out;
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [1:0] v;
    int accepted, pulses;
    reset = 1'b1; pkt_rdy_in = 1'b1;
    dcp_vld_in = 1'b0; evt_vld_in = 1'b0; dcp_data_in = '0; evt_data_in = '0;
    @(posedge clk); #2;
    model_on = 1;
    @(negedge clk);
    checkOutput("reset_vld", W'(pkt_vld_out), W'(0));
    checkOutput("reset_data", pkt_data_out, W'(0));
    checkOutput("reset_cnt", W'(ptx_cnt_out), W'(0));
    checkOutput("reset_rdy", W'({dcp_rdy_out, evt_rdy_out}), W'(0));
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_rdy", W'({dcp_rdy_out, evt_rdy_out}), W'(2'b11));

    // Event with a wrong parity bit and a payload.
    applyStimulus(0, 72'h0000_00FF_1234_5678_02);
    waitAccept(0, 10);
    @(negedge clk);
    checkOutput("t1_vld", W'(pkt_vld_out), W'(1));
    checkOutput("t1_data", pkt_data_out, 72'h0000_00FF_1234_5678_03);
    @(negedge clk);
    checkOutput("t1_cnt", W'(ptx_cnt_out), W'(2'b01));
    @(negedge clk);
    checkOutput("t1_cnt_clear", W'(ptx_cnt_out), W'(2'b00));

    // Short event: garbage payload excluded from parity but carried through.
    applyStimulus(0, 72'hFFFF_FFFF_0000_0001_01);
    waitAccept(0, 10);
    @(negedge clk);
    checkOutput("t4_data", pkt_data_out, 72'hFFFF_FFFF_0000_0001_00);
    checkOutput("t4_raw_data", raw_pkt_data, 72'hFFFF_FFFF_0000_0001_01);

    // DCP with bad parity goes through untouched.
    applyStimulus(1, 72'h0000_0000_0000_0000_00);
    waitAccept(1, 10);
    @(negedge clk);
    checkOutput("t5_vld", W'(pkt_vld_out), W'(1));
    checkOutput("t5_data", pkt_data_out, 72'h0);
    @(negedge clk);
    checkOutput("t5_cnt", W'(ptx_cnt_out), W'(2'b10));

    // Stalled link: only two of five events fit.
    nextCycle();
    pkt_rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(0, randPkt());
    accepted = 0;
    repeat (10) begin
      @(negedge clk);
      if (evt_vld_in && evt_rdy_out) accepted++;
    end
    checkOutput("t3_accepted", W'(accepted), W'(2));
    checkOutput("t3_evt_rdy", W'(evt_rdy_out), W'(0));
    nextCycle();
    pkt_rdy_in = 1'b1;
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (ptx_cnt_out == 2'b01) pulses++;
    end
    checkOutput("t3_pulses", W'(pulses), W'(5));

    // Both sources valid continuously from reset release.
    nextCycle();
    reset = 1'b1;
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, randPkt());
      applyStimulus(0, randPkt());
    end
    nextCycle();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      waitPulse(10, v);
      checkOutput("t2_order", W'(v), W'((k % 2 == 0) ? 2'b10 : 2'b01));
    end
    repeat (6) @(negedge clk);

    // Reset with a full buffer whose last winner was DCP.
    nextCycle();
    pkt_rdy_in = 1'b0;
    applyStimulus(0, randPkt());
    waitAccept(0, 10);
    applyStimulus(1, randPkt());
    waitAccept(1, 10);
    nextCycle();
    reset = 1'b1;
    nextCycle();
    applyStimulus(0, randPkt());
    applyStimulus(1, randPkt());
    @(negedge clk);
    checkOutput("t6_vld", W'(pkt_vld_out), W'(0));
    checkOutput("t6_cnt", W'(ptx_cnt_out), W'(0));
    nextCycle();
    reset = 1'b0;
    pkt_rdy_in = 1'b1;
    waitPulse(10, v);
    checkOutput("t6_first_grant", W'(v), W'(2'b10));
    repeat (6) @(negedge clk);

    // Random traffic, link back-pressure and occasional resets.
    for (int c = 0; c < 600; c++) begin
      nextCycle();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 149) == 0) reset = 1'b1;
      pkt_rdy_in = ($urandom_range(0, 9) < 7);
      if (dcp_src_q.size() < 3 && $urandom_range(0, 2) == 0) applyStimulus(1, randPkt());
      if (evt_src_q.size() < 3 && $urandom_range(0, 1) == 0) applyStimulus(0, randPkt());
    end
    nextCycle();
    reset = 1'b0;
    pkt_rdy_in = 1'b1;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
